sram_controller: RTL and testbench

Bridges the ARM pipeline's memory stage to the external 32-bit asynchronous SRAM (17-bit word address, active-low write enable, shared bidirectional data bus, 30 ns read access). Each load or store becomes a fixed-length SRAM access cycle. The block stalls the pipeline through `ready` for the duration of that access and returns load data in a holding register. It sits between the MEM stage and the SRAM device.

---
 rtl/sram_controller_if.sv | 23 ++
 rtl/sram_controller.sv | 98 +++++++++
 tb/tb_sram_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: request, address/data and stall handshake.
// Latency: n/a (signal bundle only).
// Backpressure: ready low tells the pipeline to hold its request and freeze.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  // Pipeline MEM stage drives requests and consumes data/stall.
  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  // Controller consumes requests and drives data/stall.
  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: bridges MEM-stage loads/stores to a 32-bit asynchronous SRAM.
// Latency: WAIT_CYCLES+2 cycles per access (request cycle, WAIT_CYCLES BUSY cycles, DONE).
// Backpressure: ready low from the request cycle through BUSY; MEM holds its request until ready.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave bus,
  output logic             SRAM_WE_N,
  output logic [16:0]      SRAM_ADDR,
  inout  wire  [31:0]      SRAM_DQ
);

  // Counter only needs to reach WAIT_CYCLES-1.
  localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we_n;
  logic [16:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;

  logic          w_req;
  logic [31:0]   w_offset;
  logic [16:0]   w_word;
  logic          w_unused;

  // Byte address relative to the SRAM window; wraps modulo 2^32 below BASE_ADDR.
  assign w_req    = bus.wr_en | bus.rd_en;
  assign w_offset = bus.address - BASE_ADDR;
  assign w_word   = w_offset[18:2];
  // Byte-lane bits and bits above the 17-bit word address are deliberately dropped.
  assign w_unused = ^{w_offset[31:19], w_offset[1:0]};

  // A request seen in IDLE stalls immediately; DONE releases the pipeline for one cycle.
  assign bus.ready     = ((r_state == IDLE) && !w_req) || (r_state == DONE);
  assign bus.read_data = r_rdata;

  assign SRAM_WE_N = r_we_n;
  assign SRAM_ADDR = r_addr;
  // Bus drive is tied to the write strobe itself, so DQ can never be driven while WE_N is high.
  assign SRAM_DQ   = r_we_n ? {32{1'bz}} : r_wdata;

  // Access sequencer: latch request in IDLE, hold SRAM pins through BUSY, single DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we_n  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // Write wins when both requests are present.
            r_we_n  <= ~bus.wr_en;
            r_addr  <= w_word;
            r_wdata <= bus.write_data;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == LAST) begin
            // Read data has settled by now; sample it as the bus is released.
            if (r_we_n) begin
              r_rdata <= SRAM_DQ;
            end
            r_we_n  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          // Request still held here belongs to the finished access; never restart it.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural asynchronous SRAM model.
// Latency: n/a.
// Backpressure: requests held until ready, as the MEM stage would.
module tb_sram_controller;

  logic clk;
  logic rst;

  int checks;
  int errors;

  // Default-parameter instance with a full SRAM model.
  sram_controller_if bus ();
  logic        sram_we_n;
  logic [16:0] sram_addr;
  wire  [31:0] sram_dq;
  logic [31:0] mem [0:131071];

  // Short-wait instance; its SRAM returns a fixed word on reads.
  sram_controller_if bus2 ();
  logic        sram_we_n2;
  logic [16:0] sram_addr2;
  wire  [31:0] sram_dq2;

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_WE_N (sram_we_n),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq)
  );

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .SRAM_WE_N (sram_we_n2),
    .SRAM_ADDR (sram_addr2),
    .SRAM_DQ   (sram_dq2)
  );

  // SRAM outputs its addressed word whenever it is not being written.
  assign sram_dq  = sram_we_n  ? mem[sram_addr] : {32{1'bz}};
  assign sram_dq2 = sram_we_n2 ? 32'h0BADF00D   : {32{1'bz}};

  // SRAM stores the bus value on each edge while write enable is low.
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] = sram_dq;
  end

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // One complete access as the MEM stage would issue it; reports what was seen on the SRAM pins.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat,
                            output logic [16:0] a_busy, output logic saw_we0,
                            output logic saw_we1, output logic dq_ok);
    @(negedge clk);
    bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = wdata;
    #1;
    lat = 1; saw_we0 = 1'b0; saw_we1 = 1'b0; dq_ok = 1'b1; a_busy = '1;
    while (!bus.ready && lat < 40) begin
      @(negedge clk); #1;
      lat++;
      if (!bus.ready) begin
        if (lat == 2) a_busy = sram_addr;
        if (sram_we_n) saw_we1 = 1'b1; else saw_we0 = 1'b1;
        if (sram_we_n && (sram_dq !== mem[sram_addr])) dq_ok = 1'b0;
      end
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.write_data = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #5;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b exp 1", sram_we_n); end
    checks++; if (sram_addr !== 17'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", sram_addr); end
    checks++; if (bus.read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.read_data); end
    checks++; if (sram_dq !== 32'hC0DE0000) begin errors++; $display("FAIL reset_dq_float got %h exp c0de0000", sram_dq); end
    bus.rd_en = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready_req got %b exp 0", bus.ready); end
    bus.rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    int lat; logic [16:0] a; logic w0, w1, dq_ok;
    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, a, w0, w1, dq_ok);
    checks++; if (lat !== 7) begin errors++; $display("FAIL wr_latency got %0d exp 7", lat); end
    checks++; if (a !== 17'd0) begin errors++; $display("FAIL wr_addr got %h exp 0", a); end
    checks++; if ({w0, w1} !== 2'b10) begin errors++; $display("FAIL wr_we_n got seen0/seen1 %b exp 10", {w0, w1}); end
    checks++; if (mem[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got %h exp deadbeef", mem[0]); end
    run_access(1'b0, 1'b1, 32'd1024, 32'hFFFF_FFFF, lat, a, w0, w1, dq_ok);
    checks++; if (lat !== 7) begin errors++; $display("FAIL rd_latency got %0d exp 7", lat); end
    checks++; if (a !== 17'd0) begin errors++; $display("FAIL rd_addr got %h exp 0", a); end
    checks++; if (bus.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", bus.read_data); end
    checks++; if ({w0, w1, dq_ok} !== 3'b011) begin errors++; $display("FAIL rd_bus got seen0/seen1/dq_ok %b exp 011", {w0, w1, dq_ok}); end
  endtask

  task automatic test_addr_map;
    int lat; logic [16:0] a; logic w0, w1, dq_ok;
    run_access(1'b1, 1'b0, 32'd1424, 32'h12345678, lat, a, w0, w1, dq_ok);
    checks++; if (a !== 17'd100) begin errors++; $display("FAIL map_wr_addr got %0d exp 100", a); end
    run_access(1'b0, 1'b1, 32'd1427, 32'hFFFF_FFFF, lat, a, w0, w1, dq_ok);
    checks++; if (a !== 17'd100) begin errors++; $display("FAIL map_rd_addr got %0d exp 100", a); end
    checks++; if (bus.read_data !== 32'h12345678) begin errors++; $display("FAIL map_rd_data got %h exp 12345678", bus.read_data); end
    run_access(1'b1, 1'b0, 32'd1020, 32'h0F0F0F0F, lat, a, w0, w1, dq_ok);
    checks++; if (a !== 17'h1FFFF) begin errors++; $display("FAIL map_wrap_addr got %h exp 1ffff", a); end
    checks++; if (mem[131071] !== 32'h0F0F0F0F) begin errors++; $display("FAIL map_wrap_mem got %h exp 0f0f0f0f", mem[131071]); end
  endtask

  task automatic test_latency;
    int lat; logic [16:0] a; logic w0, w1, dq_ok; logic busy_we1;
    run_access(1'b0, 1'b1, 32'd1032, 32'hFFFF_FFFF, lat, a, w0, w1, dq_ok);
    checks++; if (lat !== 7) begin errors++; $display("FAIL lat_default got %0d exp 7", lat); end
    checks++; if (bus.read_data !== 32'hC0DE0002) begin errors++; $display("FAIL lat_default_data got %h exp c0de0002", bus.read_data); end
    checks++; if ({w0, dq_ok} !== 2'b01) begin errors++; $display("FAIL lat_no_drive got seen0/dq_ok %b exp 01", {w0, dq_ok}); end
    @(negedge clk);
    bus2.rd_en = 1'b1; bus2.address = 32'd1024;
    #1;
    lat = 1; busy_we1 = 1'b1;
    while (!bus2.ready && lat < 40) begin
      @(negedge clk); #1;
      lat++;
      if (!bus2.ready && sram_we_n2 !== 1'b1) busy_we1 = 1'b0;
    end
    bus2.rd_en = 1'b0;
    checks++; if (lat !== 4) begin errors++; $display("FAIL lat_wait2 got %0d exp 4", lat); end
    checks++; if (bus2.read_data !== 32'h0BADF00D) begin errors++; $display("FAIL lat_wait2_data got %h exp 0badf00d", bus2.read_data); end
    checks++; if (busy_we1 !== 1'b1) begin errors++; $display("FAIL lat_wait2_we_n got %b exp 1", busy_we1); end
  endtask

  task automatic test_back_to_back;
    int op, cyc, pulses, starts, extra;
    logic prev_ready;
    logic [31:0] load_val;
    op = 0; cyc = 0; pulses = 0; starts = 0; extra = 0; prev_ready = 1'b1; load_val = '0;
    while (op < 3 && cyc < 100) begin
      @(negedge clk);
      case (op)
        0: begin bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = 32'd1044; bus.write_data = 32'h55AA0001; end
        1: begin bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.address = 32'd1044; bus.write_data = 32'hFFFF_FFFF; end
        default: begin bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = 32'd1048; bus.write_data = 32'h66BB0002; end
      endcase
      #1;
      cyc++;
      if (prev_ready && !bus.ready) starts++;
      if (bus.ready) begin
        pulses++;
        if (op == 1) load_val = bus.read_data;
        op++;
      end
      prev_ready = bus.ready;
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (!bus.ready || !sram_we_n) extra++;
    end
    checks++; if (cyc !== 21) begin errors++; $display("FAIL b2b_cycles got %0d exp 21", cyc); end
    checks++; if (pulses !== 3 || starts !== 3) begin errors++; $display("FAIL b2b_accesses got pulses %0d starts %0d exp 3 3", pulses, starts); end
    checks++; if (load_val !== 32'h55AA0001) begin errors++; $display("FAIL b2b_load got %h exp 55aa0001", load_val); end
    checks++; if (mem[5] !== 32'h55AA0001 || mem[6] !== 32'h66BB0002) begin errors++; $display("FAIL b2b_mem got %h %h exp 55aa0001 66bb0002", mem[5], mem[6]); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra got %0d busy cycles exp 0", extra); end
  endtask

  task automatic test_simultaneous;
    int lat; logic [16:0] a; logic w0, w1, dq_ok;
    run_access(1'b1, 1'b1, 32'd1052, 32'hA5A5A5A5, lat, a, w0, w1, dq_ok);
    checks++; if ({w0, w1} !== 2'b10) begin errors++; $display("FAIL both_we_n got seen0/seen1 %b exp 10", {w0, w1}); end
    checks++; if (mem[7] !== 32'hA5A5A5A5) begin errors++; $display("FAIL both_mem got %h exp a5a5a5a5", mem[7]); end
    checks++; if (bus.read_data !== 32'h55AA0001) begin errors++; $display("FAIL both_rdata got %h exp 55aa0001", bus.read_data); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL both_latency got %0d exp 7", lat); end
  endtask

  task automatic test_reset_mid_write;
    int lat; logic [16:0] a; logic w0, w1, dq_ok;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.address = 32'd1060; bus.write_data = 32'h13579BDF;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL mid_pre_we_n got %b exp 0", sram_we_n); end
    rst = 1'b1;
    #1;
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL mid_we_n got %b exp 1", sram_we_n); end
    checks++; if (sram_addr !== 17'd0) begin errors++; $display("FAIL mid_addr got %h exp 0", sram_addr); end
    checks++; if (sram_dq !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_dq_float got %h exp deadbeef", sram_dq); end
    checks++; if (bus.read_data !== 32'd0) begin errors++; $display("FAIL mid_rdata got %h exp 0", bus.read_data); end
    bus.wr_en = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", bus.ready); end
    checks++; if (mem[9] !== 32'hC0DE0009 && mem[9] !== 32'h13579BDF) begin errors++; $display("FAIL mid_word got %h exp c0de0009 or 13579bdf", mem[9]); end
    run_access(1'b0, 1'b1, 32'd1060, 32'hFFFF_FFFF, lat, a, w0, w1, dq_ok);
    checks++; if (lat !== 7) begin errors++; $display("FAIL mid_after_latency got %0d exp 7", lat); end
    checks++; if (bus.read_data !== mem[9]) begin errors++; $display("FAIL mid_after_data got %h exp %h", bus.read_data, mem[9]); end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 131072; i++) mem[i] = 32'hC0DE0000 ^ 32'(i);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
    bus2.wr_en = 1'b0; bus2.rd_en = 1'b0; bus2.address = '0; bus2.write_data = '0;
    test_reset;
    test_write_read;
    test_addr_map;
    test_latency;
    test_back_to_back;
    test_simultaneous;
    test_reset_mid_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
